uart_receive: RTL
=================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter: DIV_W, 32, width of the clk_div input and the bit-period counter.
REQ-002 SHALL have port: clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: clk_div  input  DIV_W  clk cycles per bit; legal values are 4 or more; it changes only while busy=0.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line; idle level is high.
REQ-006 SHALL have port: fiforx_full  input  1  RX FIFO full flag.
REQ-007 SHALL have port: fiforx_w_en  output  1  one-cycle RX FIFO write strobe.
REQ-008 SHALL have port: fiforx_w_data  output  8  received byte; valid while fiforx_w_en=1.
REQ-009 SHALL have port: busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the synchronizer output.
REQ-013 SHALL implement five states: IDLE, START_BIT, RECV_DATA, STOP_BIT, WAIT_IDLE.
REQ-014 SHALL move from IDLE to START_BIT in the cycle after rx_s=0 is seen, clearing clk_cnt.
REQ-015 SHALL, in START_BIT, check rx_s at clk_cnt==(clk_div>>1)-1: if low, go to RECV_DATA with clk_cnt=0 and bit_idx=0; if high, treat it as a glitch and return to IDLE with no output pulses.
REQ-016 SHALL, in RECV_DATA, sample rx_s into shift[bit_idx] (LSB first) at clk_cnt==clk_div-1, then reset clk_cnt and increment bit_idx; after bit_idx 7 is sampled it goes to STOP_BIT.
REQ-017 SHALL, in STOP_BIT, sample rx_s at clk_cnt==clk_div-1, giving mid-stop-bit sampling.
REQ-018 SHALL, for the STOP_BIT sample, do the following in the next cycle: if the sample is 1 and fiforx_full=0, assert fiforx_w_en for 1 cycle with the byte and go to IDLE; if the sample is 1 and fiforx_full=1, pulse overrun, write nothing and go to IDLE; if the sample is 0, pulse frame_err, write nothing and go to WAIT_IDLE.
REQ-019 SHALL leave WAIT_IDLE for IDLE only after rx_s=1, so a held-low line (break) yields exactly one frame_err.
REQ-020 SHALL accept a new start edge in IDLE immediately, allowing back-to-back frames with half a stop bit of margin.
REQ-021 SHALL hold fiforx_w_data at the last written byte between writes; fiforx_w_en, frame_err and overrun are never high in the same cycle.
REQ-022 SHALL use clk_cnt of width DIV_W, which never wraps in legal operation.

Reset
REQ-023 SHALL, while rst=1 on a clock edge, clear every output to 0 (fiforx_w_data=8'h00), clk_cnt=0, bit_idx=0 and shift=0, and set state=WAIT_IDLE.
REQ-024 SHALL abandon a frame interrupted by reset with no outputs, and SHALL NOT resynchronize until the line has been seen high.

Configuration
REQ-025 SHALL, with UART_RX_MAJORITY_EN defined, take each START/data/stop decision as the 2-of-3 majority of rx_s at sample points target-1, target and target+1; the decision and the state transition occur at target+1 and all later timing shifts by one cycle.
REQ-026 SHALL, with UART_RX_MAJORITY_EN undefined, take every decision as the single rx_s sample at the target cycle.

Structure
REQ-027 SHALL place the state encodings, the frame constants (8 data bits, 1 start bit, 1 stop bit) and the minimum clk_div value in the shared package uart_pkg, which is shared with the transmitter.
REQ-028 SHALL implement the synchronizer and the optional majority voter as one sub-module, uart_rx_sampler; the FSM and the counters stay in uart_receive.

Verification
REQ-029 SHALL verify: clk_div=8, send 0xA5 with stop=1 and fiforx_full=0 -> exactly one fiforx_w_en with data 0xA5, no error pulses, busy low afterwards.
REQ-030 SHALL verify: rx low for 2 cycles then high, clk_div=16 -> return to IDLE, no write and no error pulse.
REQ-031 SHALL verify: send 0x3C with stop=0, then hold rx low for 40 cycles -> one frame_err, no write, busy high until rx returns high.
REQ-032 SHALL verify: fiforx_full=1 during 0x55 -> one overrun pulse, fiforx_w_en stays 0, fiforx_w_data unchanged.
REQ-033 SHALL verify: back-to-back frames 0x00 and 0xFF with no idle gap -> two writes, 0x00 then 0xFF.
REQ-034 SHALL verify: assert rst during bit 3 of a frame, release it while rx is low -> no outputs until rx goes high; the next frame, 0x81, is received correctly. With UART_RX_MAJORITY_EN defined, a 1-cycle inverted glitch at the centre of bit 2 still yields the correct byte.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: state encodings, frame shape, clock-divider floor and the 2-of-3 vote helper.
// Latency: none; types, constants and a pure function only.
// Backpressure: not applicable. UART_RX_MAJORITY_EN selects the receiver's voted sampling offset.
package uart_pkg;

    // Receiver FSM states; the transmitter uses the same package for its own constants.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_RECV_DATA = 3'd2,
        ST_STOP_BIT  = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    // Frame shape: one start bit, eight data bits LSB first, one stop bit.
    localparam int UART_START_BITS = 1;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

    // Smallest clk_div that still leaves room for the half-bit start check
    // and the one-cycle voting window on either side of a sample point.
    localparam int UART_MIN_CLK_DIV = 4;

`ifdef UART_RX_MAJORITY_EN
    // Voted decisions need the sample after the target, so they land one cycle late.
    localparam int UART_RX_VOTE_DELAY = 1;
`else
    localparam int UART_RX_VOTE_DELAY = 0;
`endif

    // 2-of-3 majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchronizer, sync-valid qualifier, optional 2-of-3 voter (UART_RX_MAJORITY_EN).
// Latency: 2 clk from rx to o_rx_s; o_rx_dec votes over the current and two previous o_rx_s values.
// Backpressure: none; free-running, samples every clk.
import uart_pkg::*;

module uart_rx_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_rx_vld,
    output logic o_rx_dec
);

    logic [1:0] r_sync;
    logic [1:0] r_fill;

    // Two-stage synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // Marks when r_sync[1] holds a real line sample rather than its reset value,
    // so a line held low across reset is not mistaken for an idle high line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill <= 2'b00;
        end else begin
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    assign o_rx_s   = r_sync[1];
    assign o_rx_vld = r_fill[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keeps the two previous synchronized samples for the voting window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    // Decision taken at target+1: votes over samples target-1, target, target+1.
    assign o_rx_dec = maj3(r_hist[1], r_hist[0], r_sync[1]);
`else
    assign o_rx_dec = r_sync[1];
`endif

endmodule

// File: rtl/uart_receive.sv
// UART receiver: 8N1 deframer writing good bytes to an RX FIFO, flagging framing errors and overruns.
// Latency: byte strobed 1 clk after the mid-stop-bit decision (one clk later with UART_RX_MAJORITY_EN).
// Backpressure: none on the line; a byte arriving while fiforx_full=1 is dropped with an overrun pulse.
import uart_pkg::*;

module uart_receive #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             rx,
    input  logic             fiforx_full,
    output logic             fiforx_w_en,
    output logic [7:0]       fiforx_w_data,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] START_OFS = DIV_W'(UART_RX_VOTE_DELAY);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic w_rx_s;
    logic w_rx_vld;
    logic w_rx_dec;

    uart_rx_sampler u_sampler (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rx     (rx),
        .o_rx_s   (w_rx_s),
        .o_rx_vld (w_rx_vld),
        .o_rx_dec (w_rx_dec)
    );

    uart_state_t      r_state;
    logic [DIV_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_w_en;
    logic [7:0]       r_w_data;
    logic             r_frame_err;
    logic             r_overrun;

    uart_state_t      w_state_nxt;
    logic [DIV_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_w_en_nxt;
    logic [7:0]       w_w_data_nxt;
    logic             w_frame_err_nxt;
    logic             w_overrun_nxt;

    logic [DIV_W-1:0] w_start_tgt;
    logic [DIV_W-1:0] w_bit_tgt;

    // Start check sits half a bit in; data/stop checks a full bit after the
    // previous decision, so the voting delay is applied only once at the start.
    assign w_start_tgt = (clk_div >> 1) - CNT_ONE + START_OFS;
    assign w_bit_tgt   = clk_div - CNT_ONE;

    // State and datapath registers; reset parks in WAIT_IDLE so a frame cut by
    // reset is abandoned until the line is seen idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_w_en      <= 1'b0;
            r_w_data    <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_w_en      <= w_w_en_nxt;
            r_w_data    <= w_w_data_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state, counters and the single-cycle result pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt + CNT_ONE;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_w_en_nxt      = 1'b0;
        w_w_data_nxt    = r_w_data;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START_BIT;
                end
            end

            ST_START_BIT: begin
                if (r_clk_cnt == w_start_tgt) begin
                    w_clk_cnt_nxt = '0;
                    if (!w_rx_dec) begin
                        w_state_nxt   = ST_RECV_DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch, not a frame.
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RECV_DATA: begin
                if (r_clk_cnt == w_bit_tgt) begin
                    w_clk_cnt_nxt            = '0;
                    w_shift_nxt[r_bit_idx]   = w_rx_dec;
                    w_bit_idx_nxt            = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = ST_STOP_BIT;
                    end
                end
            end

            ST_STOP_BIT: begin
                if (r_clk_cnt == w_bit_tgt) begin
                    w_clk_cnt_nxt = '0;
                    if (w_rx_dec) begin
                        w_state_nxt = ST_IDLE;
                        if (fiforx_full) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_w_en_nxt   = 1'b1;
                            w_w_data_nxt = r_shift;
                        end
                    end else begin
                        // Low stop bit: report once, then wait out any break condition.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_WAIT_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (w_rx_vld && w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_clk_cnt_nxt = '0;
                w_state_nxt   = ST_WAIT_IDLE;
            end
        endcase
    end

    assign fiforx_w_en   = r_w_en;
    assign fiforx_w_data = r_w_data;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;
    assign busy          = (r_state != ST_IDLE) & ~rst;

endmodule
